mmio_uart_tx: RTL

Memory-mapped UART transmitter on the hart's data-memory bus. It is the peripheral that the top level decodes into the address window above the 32 KiB RAM. Stores to its TXDATA register enqueue bytes into a small FIFO. A serializer FSM drains the FIFO onto `tx` as 8N1 frames, LSB first. The hart polls a STATUS register through the same bus, with the same one-cycle read latency as the RAM's data port.

---
 rtl/mmio_uart_tx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores feed a byte FIFO, a serializer
// drains it as 8N1 frames on tx, and STATUS is polled with one-cycle read latency.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        chip_select,
    input  logic [1:0]  op,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] SEL_TXDATA = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bus decode
    logic       rd_en;
    logic       wr_en;
    logic [1:0] reg_sel;

    assign rd_en   = chip_select && (op == OP_READ);
    assign wr_en   = chip_select && (op == OP_WRITE);
    assign reg_sel = addr[3:2];

    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr[31:4], addr[1:0], data_i[31:8]};

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic empty;
    logic push_req;
    logic push_ok;
    logic pop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr_en && (reg_sel == SEL_TXDATA);
    // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_en && (reg_sel == SEL_STATUS)) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // Serializer state
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_done;
    logic          busy;

    assign bit_done = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    timer_d = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit so frames have no gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Read data reflects pre-edge state
    logic [31:0] rd_data;
    logic [31:0] data_o_q;

    always_comb begin
        rd_data = 32'd0;
        if (reg_sel == SEL_STATUS) begin
            rd_data = {28'd0, ovf_q, busy, empty, full};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= 3'd0;
            tx_q     <= 1'b1;
            data_o_q <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            if (rd_en) begin
                data_o_q <= rd_data;
            end
        end
    end

    // Byte storage and shift register carry data only; pointers gate their meaning.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
        shift_q <= shift_d;
    end

    assign data_o = data_o_q;
    assign tx     = tx_q;

endmodule
